// File: rtl/hb_down2.sv
// hb_down2: half-band FIR decimate-by-2 with symmetric pre-add, shift-only
// center tap, full-precision accumulation, floor scaling and saturation.
// Fixed six-stage pipeline: delay line, pre-add, multiply, sum, saturate, output.
module hb_down2 #(
  parameter int unsigned XIN_WIDTH      = 16,
  parameter int unsigned COE_WIDTH      = 16,
  parameter int unsigned NUM_UNIQUE_COE = 5,
  parameter int          COE_NUMS [NUM_UNIQUE_COE] = '{952, -1609, 3090, -6260, 20622},
  parameter int unsigned YOUT_WIDTH     = 16,
  parameter int unsigned SRA_BITS       = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [XIN_WIDTH-1:0]  xin0,
  input  logic signed [XIN_WIDTH-1:0]  xin1,
  input  logic                         xin_valid,
  output logic signed [YOUT_WIDTH-1:0] yout,
  output logic                         yout_valid,
  output logic                         ovf
);

  localparam int unsigned N      = NUM_UNIQUE_COE;
  localparam int unsigned PA_W   = XIN_WIDTH + 1;
  localparam int unsigned PROD_W = PA_W + COE_WIDTH;
  localparam int unsigned CTR_W  = XIN_WIDTH + SRA_BITS;
  localparam int unsigned BASE_W = (PROD_W > CTR_W) ? PROD_W : CTR_W;
  localparam int unsigned ACC_W  = BASE_W + $clog2(N + 1) + 1;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(YOUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  // Odd history d1[0] is the newest xin1; even history d0[N-1] feeds the center tap.
  logic signed [XIN_WIDTH-1:0]  d1 [2*N];
  logic signed [XIN_WIDTH-1:0]  d0 [N];
  logic signed [PA_W-1:0]       pa [N];
  logic signed [PROD_W-1:0]     prod [N];
  logic signed [COE_WIDTH-1:0]  coe [N];
  logic signed [XIN_WIDTH-1:0]  c2;
  logic signed [XIN_WIDTH-1:0]  c3;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_nxt;
  logic signed [ACC_W-1:0]      scaled;
  logic signed [YOUT_WIDTH-1:0] sat_y;
  logic signed [YOUT_WIDTH-1:0] sat_nxt;
  logic                         sat_o;
  logic                         ovf_nxt;
  logic [4:0]                   vpipe;

  // Coefficient table at the configured coefficient width.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      coe[i] = COE_WIDTH'(COE_NUMS[i]);
    end
  end

  // Delay lines advance only on qualified pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2*N; i++) d1[i] <= '0;
      for (int unsigned i = 0; i < N; i++)   d0[i] <= '0;
    end else if (xin_valid) begin
      d1[0] <= xin1;
      d0[0] <= xin0;
      for (int unsigned i = 1; i < 2*N; i++) d1[i] <= d1[i-1];
      for (int unsigned i = 1; i < N; i++)   d0[i] <= d0[i-1];
    end
  end

  // Pre-add symmetric odd taps, multiply by unique coefficient, carry center sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        pa[i]   <= '0;
        prod[i] <= '0;
      end
      c2 <= '0;
      c3 <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        pa[i]   <= PA_W'(d1[i]) + PA_W'(d1[2*N-1-i]);
        prod[i] <= PROD_W'(pa[i]) * PROD_W'(coe[i]);
      end
      c2 <= d0[N-1];
      c3 <= c2;
    end
  end

  // Full-precision sum; the center tap weight is a power of two, so it is a shift.
  always_comb begin
    acc_nxt = ACC_W'(c3) <<< SRA_BITS;
    for (int unsigned i = 0; i < N; i++) begin
      acc_nxt = acc_nxt + ACC_W'(prod[i]);
    end
  end

  // Floor scaling and clamp to the output range.
  always_comb begin
    scaled  = acc >>> (SRA_BITS + 1);
    sat_nxt = YOUT_WIDTH'(scaled);
    ovf_nxt = 1'b0;
    if (scaled > Y_MAX) begin
      sat_nxt = YOUT_WIDTH'(Y_MAX);
      ovf_nxt = 1'b1;
    end else if (scaled < Y_MIN) begin
      sat_nxt = YOUT_WIDTH'(Y_MIN);
      ovf_nxt = 1'b1;
    end
  end

  // Sum and saturation pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      sat_y <= '0;
      sat_o <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      sat_y <= sat_nxt;
      sat_o <= ovf_nxt;
    end
  end

  // Valid pipeline tracks data through the first five stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[3:0], xin_valid};
  end

  // Output register loads only with a qualified result and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yout       <= '0;
      ovf        <= 1'b0;
      yout_valid <= 1'b0;
    end else begin
      yout_valid <= vpipe[4];
      if (vpipe[4]) begin
        yout <= sat_y;
        ovf  <= sat_o;
      end
    end
  end

endmodule

// File: tb/tb_hb_down2.sv
// Scoreboard bench for hb_down2: direct-convolution reference model over the
// full sample history, directed impulse/DC/saturation/reset cases plus random traffic.
module tb_hb_down2;

  localparam int N  = 5;
  localparam int NT = 4*N - 1;
  localparam int C  = 2*N - 1;
  localparam int COE [N] = '{952, -1609, 3090, -6260, 20622};

  typedef struct {
    logic signed [15:0] y;
    logic               o;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] xin0 = '0;
  logic signed [15:0] xin1 = '0;
  logic               xin_valid = 1'b0;
  logic signed [15:0] yout;
  logic               yout_valid;
  logic               ovf;

  hb_down2 dut (
    .clk       (clk),
    .rst       (rst),
    .xin0      (xin0),
    .xin1      (xin1),
    .xin_valid (xin_valid),
    .yout      (yout),
    .yout_valid(yout_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int                 n_cmp = 0;
  int                 n_err = 0;
  longint             h [NT];
  longint             xs [$];
  exp_t               exp_q [$];
  logic signed [15:0] got [$];
  logic               got_o [$];
  logic signed [15:0] last_y = '0;
  logic               last_o = 1'b0;
  logic [5:0]         vsh;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: y[m] = sat(floor(sum h[k]*x[2m+1-k] / 2^16)) over the raw sample stream.
  function automatic exp_t model_out();
    longint acc = 0;
    int     idx;
    exp_t   e;
    for (int k = 0; k < NT; k++) begin
      idx = xs.size() - 1 - k;
      if (idx >= 0) acc += h[k] * xs[idx];
    end
    acc = acc >>> 16;
    if (acc > 32767)       begin e.y = 16'sd32767; e.o = 1'b1; end
    else if (acc < -32768) begin e.y = -16'sd32768; e.o = 1'b1; end
    else                   begin e.y = 16'(acc);    e.o = 1'b0; end
    return e;
  endfunction

  task automatic drive(input logic signed [15:0] a, input logic signed [15:0] b, input logic v);
    @(posedge clk);
    #1;
    xin0 = a;
    xin1 = b;
    xin_valid = v;
    if (v) begin
      xs.push_back(longint'(a));
      xs.push_back(longint'(b));
      exp_q.push_back(model_out());
    end
  endtask

  task automatic drain();
    repeat (9) drive(16'sd0, 16'sd0, 1'b0);
  endtask

  // Expected yout_valid: xin_valid delayed six cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) vsh <= '0;
    else     vsh <= {vsh[4:0], xin_valid};
  end

  // Monitor: pops the scoreboard on every valid output and checks hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("reset_state", {yout, ovf, yout_valid}, 0);
      last_y = '0;
      last_o = 1'b0;
    end else begin
      chk("yout_valid", yout_valid, vsh[5]);
      if (yout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("yout", yout, e.y);
          chk("ovf", ovf, e.o);
        end
        got.push_back(yout);
        got_o.push_back(ovf);
        last_y = yout;
        last_o = ovf;
      end else begin
        chk("yout_hold", yout, last_y);
        chk("ovf_hold", ovf, last_o);
      end
    end
  end

  logic signed [15:0] odd_tab [11] = '{14, -25, 47, -96, 314, 314, -96, 47, -25, 14, 0};
  logic signed [15:0] even_tab [10] = '{0, 0, 0, 0, 500, 0, 0, 0, 0, 0};

  initial begin
    for (int k = 0; k < NT; k++) h[k] = 0;
    h[C] = 32768;
    for (int j = 0; j < N; j++) begin
      h[C-(2*j+1)] = COE[N-1-j];
      h[C+(2*j+1)] = COE[N-1-j];
    end

    // Power-on reset
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Odd impulse, continuous valid
    got.delete();
    drive(16'sd0, 16'sd1000, 1'b1);
    repeat (14) drive(16'sd0, 16'sd0, 1'b1);
    drain();
    chk("odd_count", got.size(), 15);
    for (int i = 0; i < 11; i++) if (i < got.size()) chk("odd_impulse", got[i], odd_tab[i]);

    // Even impulse
    got.delete();
    drive(16'sd1000, 16'sd0, 1'b1);
    repeat (12) drive(16'sd0, 16'sd0, 1'b1);
    drain();
    for (int i = 0; i < 10; i++) if (i < got.size()) chk("even_impulse", got[i], even_tab[i]);

    // Odd impulse with alternating valid; invalid beats carry junk
    got.delete();
    drive(16'sd0, 16'sd1000, 1'b1);
    drive(16'sd777, -16'sd555, 1'b0);
    repeat (13) begin
      drive(16'sd0, 16'sd0, 1'b1);
      drive(16'(16'($urandom)), 16'(16'($urandom)), 1'b0);
    end
    drain();
    for (int i = 0; i < 11; i++) if (i < got.size()) chk("gapped_impulse", got[i], odd_tab[i]);

    // DC
    got.delete();
    repeat (20) drive(16'sd16384, 16'sd16384, 1'b1);
    drain();
    chk("dc_value", got[got.size()-1], 16589);
    chk("dc_ovf", got_o[got_o.size()-1], 0);

    // Positive and negative saturation, then recovery
    got.delete();
    repeat (20) drive(16'sd32767, 16'sd32767, 1'b1);
    drain();
    chk("sat_pos", got[got.size()-1], 32767);
    chk("sat_pos_ovf", got_o[got_o.size()-1], 1);
    got.delete();
    repeat (20) drive(-16'sd32768, -16'sd32768, 1'b1);
    drain();
    chk("sat_neg", got[got.size()-1], -32768);
    chk("sat_neg_ovf", got_o[got_o.size()-1], 1);
    got.delete();
    repeat (10) drive(16'sd0, 16'sd0, 1'b1);
    drain();
    chk("ovf_clear", got_o[got_o.size()-1], 0);

    // Random traffic with random gaps
    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom), 16'($urandom), 1'(($urandom % 10) < 7));
    end
    drain();

    // Asynchronous reset mid-stream during DC
    repeat (10) drive(16'sd16384, 16'sd16384, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_yout", yout, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_valid", yout_valid, 0);
    xin_valid = 1'b0;
    xs.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    got.delete();
    repeat (15) drive(16'sd0, 16'sd0, 1'b1);
    drain();
    chk("post_rst_count", got.size(), 15);
    for (int i = 0; i < got.size(); i++) chk("post_rst_zero", got[i], 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
